// File: rtl/cordic_pkg.sv
// -----------------------------------------------------------------------------
// cordic_pkg
// Shared encodings for the multimode CORDIC control unit:
//   - coordinate-system (mode) encodings as presented on the mode input
//   - controller state encodings
//   - hyperbolic repeat-step indices (4, 13, 40) and a lookup helper
// -----------------------------------------------------------------------------
package cordic_pkg;

    typedef enum logic [1:0] {
        MODE_LIN     = 2'b00,
        MODE_CIRC    = 2'b01,
        MODE_HYP     = 2'b10,
        MODE_ILLEGAL = 2'b11
    } cordic_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_INIT = 2'b01,
        ST_CALC = 2'b10,
        ST_DONE = 2'b11
    } cu_state_e;

    // Hyperbolic CORDIC only converges if these shift indices are executed twice.
    localparam int unsigned REPEAT_IDX_0 = 4;
    localparam int unsigned REPEAT_IDX_1 = 13;
    localparam int unsigned REPEAT_IDX_2 = 40;

    // Index is passed at full 32-bit width so the compare never truncates the
    // constants (40 does not fit a 4-bit index).
    function automatic logic is_repeat_idx(input logic [31:0] idx);
        return (idx == REPEAT_IDX_0) || (idx == REPEAT_IDX_1) || (idx == REPEAT_IDX_2);
    endfunction

endpackage

// File: rtl/cordic_iter_counter.sv
// -----------------------------------------------------------------------------
// cordic_iter_counter
// Shift-index counter for the CORDIC control unit. Holds the current index and
// the hyperbolic repeat flag, initialises the index per coordinate system and
// flags the terminal step.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   init_i      : load start index (1 for hyperbolic, else 0), clear repeat flag
//   step_i      : advance one CORDIC step (hold once on a repeat index)
//   hyp_i       : current operation is hyperbolic
//   idx_o       : current shift index
//   last_o      : current step is the final one of the operation
// -----------------------------------------------------------------------------
module cordic_iter_counter
    import cordic_pkg::*;
#(
    parameter int N_ITER     = 24,
    parameter int ITER_W     = 6,
    parameter bit HYP_REPEAT = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_i,
    input  logic              step_i,
    input  logic              hyp_i,
    output logic [ITER_W-1:0] idx_o,
    output logic              last_o
);

    localparam logic [ITER_W-1:0] IDX_LAST_LC  = ITER_W'(N_ITER - 1);
    localparam logic [ITER_W-1:0] IDX_LAST_HYP = ITER_W'(N_ITER);

    logic [ITER_W-1:0] idx_q;
    logic              rep_q;
    logic              rep_pending;

    // A repeat is pending when this hyperbolic step sits on a repeat index that
    // has not yet been executed twice.
    always_comb begin
        rep_pending = HYP_REPEAT && hyp_i && is_repeat_idx(32'(idx_q)) && !rep_q;
        if (hyp_i) begin
            last_o = (idx_q == IDX_LAST_HYP) && !rep_pending;
        end else begin
            last_o = (idx_q == IDX_LAST_LC);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
            rep_q <= 1'b0;
        end else if (init_i) begin
            idx_q <= hyp_i ? ITER_W'(1) : '0;
            rep_q <= 1'b0;
        end else if (step_i) begin
            if (rep_pending) begin
                rep_q <= 1'b1;
            end else begin
                idx_q <= idx_q + 1'b1;
                rep_q <= 1'b0;
            end
        end
    end

    assign idx_o = idx_q;

endmodule

// File: rtl/cordic_multimode_cu.sv
// -----------------------------------------------------------------------------
// cordic_multimode_cu
// Control unit for the shared X/Y/Z floating-point CORDIC datapath supporting
// linear, circular and hyperbolic coordinates in rotation or vectoring mode.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   start, mode, vectoring: operation request, sampled only in IDLE
//   sign_y, sign_z        : sign bits of the live Y/Z registers (same-cycle use)
//   abort                 : synchronous cancel, returns to IDLE without done
//   loadX/Y/Z, loadMode   : datapath register load enables
//   sel_input             : datapath muxes take external operands (INIT)
//   sigma_neg             : negative rotation direction for this step
//   shift_amt             : shift index / atan-atanh ROM address
//   mode_q                : latched coordinate system
//   busy, done, err       : status; err qualifies the one-cycle done pulse
// All outputs decode state/registers (plus the sign inputs), never start.
// -----------------------------------------------------------------------------
module cordic_multimode_cu
    import cordic_pkg::*;
#(
    parameter int N_ITER     = 24,
    parameter int ITER_W     = 6,
    parameter bit HYP_REPEAT = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              vectoring,
    input  logic              sign_y,
    input  logic              sign_z,
    input  logic              abort,
    output logic              loadX,
    output logic              loadY,
    output logic              loadZ,
    output logic              loadMode,
    output logic              sel_input,
    output logic              sigma_neg,
    output logic [ITER_W-1:0] shift_amt,
    output logic [1:0]        mode_q,
    output logic              busy,
    output logic              done,
    output logic              err
);

    cu_state_e    state_q;
    cordic_mode_e mode_lat_q;
    logic         vec_q;
    logic         err_q;

    logic [ITER_W-1:0] idx;
    logic              last_step;
    logic              in_init;
    logic              in_calc;

    assign in_init = (state_q == ST_INIT);
    assign in_calc = (state_q == ST_CALC);

    cordic_iter_counter #(
        .N_ITER     (N_ITER),
        .ITER_W     (ITER_W),
        .HYP_REPEAT (HYP_REPEAT)
    ) u_iter_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .init_i (in_init),
        .step_i (in_calc),
        .hyp_i  (mode_lat_q == MODE_HYP),
        .idx_o  (idx),
        .last_o (last_step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            mode_lat_q <= MODE_LIN;
            vec_q      <= 1'b0;
            err_q      <= 1'b0;
        end else if (abort && (state_q != ST_IDLE)) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (mode == MODE_ILLEGAL) begin
                            // mode_q keeps the last legal mode on an illegal request.
                            err_q   <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            mode_lat_q <= cordic_mode_e'(mode);
                            vec_q      <= vectoring;
                            err_q      <= 1'b0;
                            state_q    <= ST_INIT;
                        end
                    end
                end
                ST_INIT: state_q <= ST_CALC;
                ST_CALC: begin
                    if (last_step) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // NOTE: every output gets a default first so no path through this block
    // can leave a value unassigned and infer a latch.
    always_comb begin
        loadX     = 1'b0;
        loadY     = 1'b0;
        loadZ     = 1'b0;
        loadMode  = 1'b0;
        sel_input = 1'b0;
        sigma_neg = 1'b0;
        shift_amt = '0;
        if (in_init) begin
            loadX     = 1'b1;
            loadY     = 1'b1;
            loadZ     = 1'b1;
            loadMode  = 1'b1;
            sel_input = 1'b1;
        end else if (in_calc) begin
            // Linear CORDIC leaves X untouched across iterations.
            loadX     = (mode_lat_q != MODE_LIN);
            loadY     = 1'b1;
            loadZ     = 1'b1;
            shift_amt = idx;
            sigma_neg = vec_q ? ~sign_y : sign_z;
        end
    end

    assign mode_q = mode_lat_q;
    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE);
    assign err    = (state_q == ST_DONE) && err_q;

endmodule
